// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : uart_pkg
//  Purpose  : Shared UART constants and receiver state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Data bits per frame (8N1 framing)
    localparam int DATA_BITS = 8;

    // 100 MHz fabric clock / 115200 baud, shared with the transmitter
    localparam int DEFAULT_CLKS_PER_BIT = 868;

    // Receiver state machine encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module   : sync_2ff
//  Purpose  : Two-flop single-bit synchronizer for asynchronous inputs.
//             The reset value is chosen to match the input's idle level.
//  Revision : 1.0 - initial release
// ============================================================================
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input into the clk domain
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : uart_rx
//  Purpose  : 8N1 UART receiver with mid-bit sampling, a one-entry
//             valid/ready holding register, framing-error and overrun pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int               CNT_W      = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] c_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] c_HALF_LAST = CNT_W'(HALF_BIT - 1);
    localparam logic [2:0]       c_IDX_LAST  = 3'(DATA_BITS - 1);

    logic                 w_rx_s;
    logic                 r_rx_q;

    state_t               r_state,     w_state_nxt;
    logic [CNT_W-1:0]     r_cnt,       w_cnt_nxt;
    logic [2:0]           r_bit_idx,   w_bit_idx_nxt;
    logic [DATA_BITS-1:0] r_shift,     w_shift_nxt;
    logic [DATA_BITS-1:0] r_data,      w_data_nxt;
    logic                 r_valid,     w_valid_nxt;
    logic                 r_frame_err, w_frame_err_nxt;
    logic                 r_overrun,   w_overrun_nxt;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (reset),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    // Previous synchronized level for falling-edge detection
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_q <= 1'b1;
        end else begin
            r_rx_q <= w_rx_s;
        end
    end

    // State, counters, shift register and holding register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_data      <= w_data_nxt;
            r_valid     <= w_valid_nxt;
            r_frame_err <= w_frame_err_nxt;
            r_overrun   <= w_overrun_nxt;
        end
    end

    // Next-state logic: frame sequencing and holding-register update
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_data_nxt      = r_data;
        // A handshake empties the register unless a load below refills it
        w_valid_nxt     = r_valid & ~rx_ready;
        w_frame_err_nxt = 1'b0;
        w_overrun_nxt   = 1'b0;

        case (r_state)
            IDLE: begin
                // Arm only on a falling edge so a held-low line never re-triggers
                if (r_rx_q && !w_rx_s) begin
                    w_state_nxt = START;
                    w_cnt_nxt   = '0;
                end
            end
            START: begin
                if (r_cnt == c_HALF_LAST) begin
                    w_cnt_nxt = '0;
                    if (!w_rx_s) begin
                        w_state_nxt   = DATA;
                        w_bit_idx_nxt = '0;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            DATA: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt              = '0;
                    w_shift_nxt[r_bit_idx] = w_rx_s;
                    if (r_bit_idx == c_IDX_LAST) begin
                        w_state_nxt = STOP;
                    end else begin
                        w_bit_idx_nxt = r_bit_idx + 3'd1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            STOP: begin
                if (r_cnt == c_BIT_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = IDLE;
                    if (w_rx_s) begin
                        if (!r_valid || rx_ready) begin
                            w_data_nxt  = r_shift;
                            w_valid_nxt = 1'b1;
                        end else begin
                            w_overrun_nxt = 1'b1;
                        end
                    end else begin
                        w_frame_err_nxt = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign rx_data   = r_data;
    assign rx_valid  = r_valid;
    assign frame_err = r_frame_err;
    assign overrun   = r_overrun;
    assign busy      = (r_state != IDLE);

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_uart_rx
//  Purpose  : Self-checking bench for uart_rx at 16 clocks per bit.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int CPB = 16;

    logic       clk;
    logic       reset;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    int         n_total = 0;
    int         n_bad   = 0;
    int         n_ferr  = 0;
    int         n_ovr   = 0;
    logic [7:0] sb[$];

    uart_rx #(
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One serial bit time, aligned just after a rising edge
    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    // Start bit, 8 data bits LSB first, stop bit at the given level
    task automatic send_frame(input logic [7:0] b, input logic stop);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard consumer and pulse counters
    always @(negedge clk) begin
        if (!reset) begin
            if (frame_err) n_ferr++;
            if (overrun)   n_ovr++;
            if (rx_valid && rx_ready) begin
                chk("sb_avail", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) chk("sb_data", 32'(rx_data), 32'(sb.pop_front()));
            end
        end
    end

    initial begin : main
        int cyc;
        int f0;
        int o0;
        int nbusy;
        int first_busy;
        logic [7:0] d0;

        reset    = 1'b1;
        rx       = 1'b1;
        rx_ready = 1'b0;
        idle(4);
        chk("rst_data",  32'(rx_data),   32'h0);
        chk("rst_valid", 32'(rx_valid),  32'h0);
        chk("rst_ferr",  32'(frame_err), 32'h0);
        chk("rst_ovr",   32'(overrun),   32'h0);
        chk("rst_busy",  32'(busy),      32'h0);
        reset = 1'b0;
        idle(4);

        // Plain byte with consumer always ready; latency from line edge
        rx_ready = 1'b1;
        f0 = n_ferr;
        sb.push_back(8'hA5);
        fork
            send_frame(8'hA5, 1'b1);
            begin
                cyc = 0;
                while (!rx_valid && cyc < 400) begin
                    @(posedge clk);
                    #1;
                    cyc++;
                end
                chk("a5_latency", 32'(cyc), 32'd155);
                @(posedge clk);
                #1;
                chk("a5_pulse_len", 32'(rx_valid), 32'd0);
            end
        join
        idle(8);
        chk("a5_ferr", 32'(n_ferr - f0), 32'd0);

        // Short low glitch on an idle line
        f0 = n_ferr;
        o0 = n_ovr;
        nbusy = 0;
        first_busy = -1;
        rx = 1'b0;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (i == 5) rx = 1'b1;
            if (busy) begin
                nbusy++;
                if (first_busy < 0) first_busy = i;
            end
        end
        chk("glitch_busy_cycles", 32'(nbusy), 32'd8);
        chk("glitch_busy_start", 32'(first_busy), 32'd3);
        chk("glitch_valid", 32'(rx_valid), 32'd0);
        chk("glitch_pulses", 32'(n_ferr - f0 + n_ovr - o0), 32'd0);

        // Framing error, then a break, then a good byte
        f0 = n_ferr;
        send_frame(8'h3C, 1'b0);
        idle(100);
        chk("ferr_count", 32'(n_ferr - f0), 32'd1);
        chk("ferr_valid", 32'(rx_valid), 32'd0);
        chk("break_busy", 32'(busy), 32'd0);
        rx = 1'b1;
        idle(CPB);
        sb.push_back(8'h55);
        send_frame(8'h55, 1'b1);
        idle(8);
        chk("after_break_ferr", 32'(n_ferr - f0), 32'd1);

        // Overrun: second byte dropped while first is held
        rx_ready = 1'b0;
        o0 = n_ovr;
        sb.push_back(8'h11);
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        idle(4);
        chk("ovr_count", 32'(n_ovr - o0), 32'd1);
        chk("ovr_data_kept", 32'(rx_data), 32'h11);
        chk("ovr_valid", 32'(rx_valid), 32'd1);
        rx_ready = 1'b1;
        idle(1);
        chk("ovr_drain_valid", 32'(rx_valid), 32'd0);
        rx_ready = 1'b0;
        idle(4);

        // Load coinciding with handshake of the held byte
        o0 = n_ovr;
        sb.push_back(8'h01);
        send_frame(8'h01, 1'b1);
        idle(4);
        sb.push_back(8'h02);
        fork
            send_frame(8'h02, 1'b1);
            begin
                repeat (154) @(posedge clk);
                #1;
                rx_ready = 1'b1;
                @(posedge clk);
                #1;
                rx_ready = 1'b0;
                chk("same_cycle_valid", 32'(rx_valid), 32'd1);
                chk("same_cycle_data", 32'(rx_data), 32'h02);
            end
        join
        idle(4);
        chk("same_cycle_ovr", 32'(n_ovr - o0), 32'd0);
        d0 = rx_data;
        chk("held_stable", 32'(d0), 32'h02);

        // Reset in the middle of the data bits
        fork
            send_frame(8'hFF, 1'b1);
            begin
                repeat (85) @(posedge clk);
                #1;
                chk("pre_rst_busy", 32'(busy), 32'd1);
                reset = 1'b1;
                sb.delete();
                @(posedge clk);
                #1;
                chk("midrst_data",  32'(rx_data),   32'h0);
                chk("midrst_valid", 32'(rx_valid),  32'h0);
                chk("midrst_ferr",  32'(frame_err), 32'h0);
                chk("midrst_ovr",   32'(overrun),   32'h0);
                chk("midrst_busy",  32'(busy),      32'h0);
                reset = 1'b0;
            end
        join
        idle(CPB);
        chk("post_rst_busy", 32'(busy), 32'd0);
        rx_ready = 1'b1;
        sb.push_back(8'h80);
        send_frame(8'h80, 1'b1);
        idle(8);

        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire
